inst_encoder: RTL and testbench
===============================

# inst_encoder

- Sequential RV32I instruction encoder; the inverse of the control-path decoder.
- Accepts instruction fields (format class, funct3, alt bit, register indices, immediate) over a valid/ready handshake and checks the combination for legality.
- Legal instructions are packed into 32-bit RV32I words and buffered in a small FIFO; illegal ones are dropped and counted.
- Used by the self-test/boot program generator to write instruction memory and to produce golden instruction streams for the single-cycle core.

## Interface
- `DEPTH`, default 4: output FIFO depth in words, power of two, ≥2.
- `i_clk` input 1: single clock, rising edge.
- `i_rst_n` input 1: asynchronous active-low reset.
- `i_valid` input 1: upstream field bundle valid.
- `o_ready` output 1: encoder can accept; equals FIFO count < `DEPTH`.
- `i_fmt` input 4: 0 R, 1 I-ALU, 2 load, 3 store, 4 branch, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC; 9–15 illegal.
- `i_funct3` input 3: funct3 field.
- `i_alt` input 1: funct7[5] (SUB/SRA/SRAI select).
- `i_rd`, `i_rs1`, `i_rs2` input 5 each: register indices.
- `i_imm` input 32: byte-offset/immediate value, sign-extended form.
- `o_valid` output 1: FIFO head word valid.
- `i_ready` input 1: downstream accepts head word.
- `o_instr` output 32: encoded instruction at FIFO head.
- `o_err` output 1: one-cycle pulse when an accepted bundle was rejected.
- `o_err_cnt` output 8: saturating count of rejected bundles.

## Operation
- Accept occurs when `i_valid && o_ready`.
- The bundle is encoded combinationally and written at the same edge if legal. If illegal it is consumed, not written, and `o_err` pulses.
- Opcodes:
  - R 0110011, I 0010011, L 0000011, S 0100011, B 1100011
  - JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111
- Field placement per the RV32I base formats:
  - R: funct7 = `{1'b0,i_alt,5'b0}`.
  - I shifts (funct3 001/101): `imm[11:0] = {1'b0,i_alt,5'b0,i_imm[4:0]}`.
  - B: imm[12|10:5], rs2, rs1, f3, imm[4:1|11].
  - J: imm[20|10:1|11|19:12].
  - U: `i_imm[31:12]`.
  - JALR forces funct3 000.
  - U, J, B and S ignore unused register fields.
- Always-on legality rules (reject if violated):
  - `i_fmt` ≤ 8.
  - R: `i_alt` only with funct3 000 or 101.
  - I: `i_alt` only with funct3 101.
  - Load: funct3 ∈ {000,001,010,100,101}.
  - Store: funct3 ≤ 010.
  - Branch: funct3 ∉ {010,011}.
- FIFO:
  - Circular, with `$clog2(DEPTH)` pointers that wrap modulo `DEPTH` and a count of width `$clog2(DEPTH)+1`.
  - Pop occurs on `o_valid && i_ready`.
  - Push and pop in the same cycle leave the count unchanged.
  - When full, `o_ready` is 0; a pop in that cycle raises `o_ready` only in the next cycle (no combinational bypass).
  - Empty: `o_valid` = 0 and `o_instr` holds its last value.
- `o_err_cnt` increments per rejection and saturates at 255.

## Timing
- Reset (asynchronous, while `i_rst_n` = 0):
  - Pointers and count = 0.
  - `o_valid` = 0, `o_instr` = 0, `o_err` = 0, `o_err_cnt` = 0, `o_ready` = 1 after release.
- Latency: a word accepted at edge N appears with `o_valid` = 1 after edge N (registered FIFO read). No combinational path from `i_valid` to `o_valid`.
- `o_err` is registered and is high for exactly the cycle after the rejecting edge.
- `o_instr` and `o_valid` are stable while `o_valid && !i_ready`.
- Reset asserted mid-stream discards all buffered words. Counter and pulse clear immediately.

## Configuration
- Macro `INST_ENCODER_IMM_CHECK_EN` defined: immediate range checks join the legality rules. Reject when any of the following fails:
  - I/L/S/JALR: `i_imm` is a sign-extended 12-bit value.
  - Shifts: `i_imm[31:5]` = 0.
  - Branch: sign-extended 13-bit with `i_imm[0]` = 0.
  - JAL: sign-extended 21-bit with `i_imm[0]` = 0.
  - LUI/AUIPC: `i_imm[11:0]` = 0.
- Macro undefined: out-of-range immediates are truncated silently to the field bits; only the always-on rules reject.

## Test plan
- R-type and I-type encodings:
  - fmt 0, f3 000, alt 0, rd 3, rs1 1, rs2 2 → 0x002081B3.
  - fmt 1, f3 000, rd 1, rs1 0, imm −1 → 0xFFF00093.
  - fmt 1, f3 101, alt 1, rd 1, rs1 1, imm 3 → 0x4030D093.
- Store, branch and LUI encodings:
  - fmt 3, f3 010, rs1 1, rs2 2, imm 4 → 0x0020A223.
  - fmt 4, f3 000, imm 8 → 0x00000463.
  - fmt 7, rd 5, imm 0x12345000 → 0x123452B7.
- Illegal inputs:
  - fmt 4 with f3 010 → no word written, `o_err` pulses for one cycle, `o_err_cnt` = 1.
  - fmt 12 → `o_err_cnt` = 2.
- Backpressure:
  - `i_ready` = 0 and 5 legal pushes with `DEPTH` 4 → `o_ready` drops after the 4th; the 5th is held upstream.
  - Release `i_ready` → words emerge in order, one per cycle.
  - Simultaneous push and pop at count 2 → count stays 2.
- Immediate check with the macro defined: fmt 4, imm 7 (odd) → rejected. Without the macro → 0x00000363 (imm[0] dropped, encodes +6).
- Reset mid-stream: assert `i_rst_n` = 0 with 3 words queued → `o_valid` = 0 immediately; after release, count = 0 and `o_ready` = 1.

Source files
------------

// File: rtl/inst_encoder.sv
`default_nettype none
// =============================================================================
// Module   : inst_encoder
// Brief    : RV32I field-bundle encoder with legality check and output FIFO.
//            Optional macro INST_ENCODER_IMM_CHECK_EN adds immediate range checks.
// Revision : 1.0 - initial release
// =============================================================================
module inst_encoder #(
   parameter int DEPTH = 4
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [3:0]  i_fmt,
   input  logic [2:0]  i_funct3,
   input  logic        i_alt,
   input  logic [4:0]  i_rd,
   input  logic [4:0]  i_rs1,
   input  logic [4:0]  i_rs2,
   input  logic [31:0] i_imm,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [31:0] o_instr,
   output logic        o_err,
   output logic [7:0]  o_err_cnt
);

   localparam int           c_AW        = $clog2(DEPTH);
   localparam logic [c_AW:0] c_DEPTH_CNT = (c_AW+1)'(DEPTH);
   localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);

   localparam logic [6:0] c_OP_R     = 7'b0110011;
   localparam logic [6:0] c_OP_I     = 7'b0010011;
   localparam logic [6:0] c_OP_L     = 7'b0000011;
   localparam logic [6:0] c_OP_S     = 7'b0100011;
   localparam logic [6:0] c_OP_B     = 7'b1100011;
   localparam logic [6:0] c_OP_JAL   = 7'b1101111;
   localparam logic [6:0] c_OP_JALR  = 7'b1100111;
   localparam logic [6:0] c_OP_LUI   = 7'b0110111;
   localparam logic [6:0] c_OP_AUIPC = 7'b0010111;

   logic [31:0]     r_mem [DEPTH];
   logic [c_AW-1:0] r_wr_ptr, r_rd_ptr, w_rd_ptr_nx;
   logic [c_AW:0]   r_count, w_count_nx;
   logic            r_valid;
   logic [31:0]     r_instr;
   logic            r_err;
   logic [7:0]      r_err_cnt;

   logic [31:0] w_word;
   logic        w_fmt_ok, w_imm_ok, w_legal, w_shift;
   logic        w_accept, w_push, w_pop;

   assign w_shift = (i_fmt == 4'd1) && ((i_funct3 == 3'b001) || (i_funct3 == 3'b101));

   always_comb begin
      w_word   = '0;
      w_fmt_ok = 1'b0;
      case (i_fmt)
         4'd0: begin
            w_word   = {1'b0, i_alt, 5'b0, i_rs2, i_rs1, i_funct3, i_rd, c_OP_R};
            w_fmt_ok = !i_alt || (i_funct3 == 3'b000) || (i_funct3 == 3'b101);
         end
         4'd1: begin
            if (w_shift)
               w_word = {1'b0, i_alt, 5'b0, i_imm[4:0], i_rs1, i_funct3, i_rd, c_OP_I};
            else
               w_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, c_OP_I};
            w_fmt_ok = !i_alt || (i_funct3 == 3'b101);
         end
         4'd2: begin
            w_word   = {i_imm[11:0], i_rs1, i_funct3, i_rd, c_OP_L};
            w_fmt_ok = (i_funct3 != 3'b011) && (i_funct3 != 3'b110) && (i_funct3 != 3'b111);
         end
         4'd3: begin
            w_word   = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], c_OP_S};
            w_fmt_ok = (i_funct3 <= 3'b010);
         end
         4'd4: begin
            w_word   = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                        i_imm[4:1], i_imm[11], c_OP_B};
            w_fmt_ok = (i_funct3 != 3'b010) && (i_funct3 != 3'b011);
         end
         4'd5: begin
            w_word   = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, c_OP_JAL};
            w_fmt_ok = 1'b1;
         end
         4'd6: begin
            w_word   = {i_imm[11:0], i_rs1, 3'b000, i_rd, c_OP_JALR};
            w_fmt_ok = 1'b1;
         end
         4'd7: begin
            w_word   = {i_imm[31:12], i_rd, c_OP_LUI};
            w_fmt_ok = 1'b1;
         end
         4'd8: begin
            w_word   = {i_imm[31:12], i_rd, c_OP_AUIPC};
            w_fmt_ok = 1'b1;
         end
         default: begin
            w_word   = '0;
            w_fmt_ok = 1'b0;
         end
      endcase
   end

`ifdef INST_ENCODER_IMM_CHECK_EN
   // Sign-extension holds when all bits above the field's sign bit match it.
   logic w_sx12, w_sx13, w_sx21;
   assign w_sx12 = (&i_imm[31:11]) || !(|i_imm[31:11]);
   assign w_sx13 = (&i_imm[31:12]) || !(|i_imm[31:12]);
   assign w_sx21 = (&i_imm[31:20]) || !(|i_imm[31:20]);

   always_comb begin
      w_imm_ok = 1'b1;
      case (i_fmt)
         4'd1:       w_imm_ok = w_shift ? !(|i_imm[31:5]) : w_sx12;
         4'd2, 4'd3,
         4'd6:       w_imm_ok = w_sx12;
         4'd4:       w_imm_ok = w_sx13 && !i_imm[0];
         4'd5:       w_imm_ok = w_sx21 && !i_imm[0];
         4'd7, 4'd8: w_imm_ok = !(|i_imm[11:0]);
         default:    w_imm_ok = 1'b1;
      endcase
   end
`else
   assign w_imm_ok = 1'b1;
`endif

   assign w_legal  = w_fmt_ok && w_imm_ok;
   assign o_ready  = (r_count < c_DEPTH_CNT);
   assign w_accept = i_valid && o_ready;
   assign w_push   = w_accept && w_legal;
   assign w_pop    = r_valid && i_ready;

   assign w_rd_ptr_nx = w_pop ? (r_rd_ptr + c_PTR_ONE) : r_rd_ptr;

   always_comb begin
      w_count_nx = r_count;
      if (w_push && !w_pop)
         w_count_nx = r_count + 1'b1;
      else if (!w_push && w_pop)
         w_count_nx = r_count - 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= w_word;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_valid   <= 1'b0;
         r_instr   <= '0;
         r_err     <= 1'b0;
         r_err_cnt <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         r_rd_ptr <= w_rd_ptr_nx;
         r_count  <= w_count_nx;
         r_valid  <= (w_count_nx != '0);
         // New head comes from the incoming word when the queue was empty or drains to it.
         if (w_count_nx != '0) begin
            if ((r_count == '0) || (w_pop && (r_count == 1)))
               r_instr <= w_word;
            else
               r_instr <= r_mem[w_rd_ptr_nx];
         end
         r_err <= w_accept && !w_legal;
         if (w_accept && !w_legal && (r_err_cnt != 8'hFF))
            r_err_cnt <= r_err_cnt + 8'd1;
      end
   end

   assign o_valid   = r_valid;
   assign o_instr   = r_instr;
   assign o_err     = r_err;
   assign o_err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_inst_encoder.sv
`default_nettype none
// =============================================================================
// Module   : tb_inst_encoder
// Brief    : Directed scoreboard bench for inst_encoder (DEPTH 4).
// Revision : 1.0 - initial release
// =============================================================================
module tb_inst_encoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic [3:0]  i_fmt = '0;
   logic [2:0]  i_funct3 = '0;
   logic        i_alt = 1'b0;
   logic [4:0]  i_rd = '0, i_rs1 = '0, i_rs2 = '0;
   logic [31:0] i_imm = '0;
   logic        o_valid;
   logic        i_ready = 1'b0;
   logic [31:0] o_instr;
   logic        o_err;
   logic [7:0]  o_err_cnt;

   int checks = 0;
   int failures = 0;
   int pops = 0;
   logic [31:0] q[$];

   always #5 clk = ~clk;

   inst_encoder #(.DEPTH(4)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_fmt(i_fmt), .i_funct3(i_funct3), .i_alt(i_alt), .i_rd(i_rd),
      .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm), .o_valid(o_valid),
      .i_ready(i_ready), .o_instr(o_instr), .o_err(o_err), .o_err_cnt(o_err_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Pops happen at the next rising edge; sample the head half a cycle earlier.
   always @(negedge clk) begin
      if (rst_n && o_valid && i_ready) begin
         if (q.size() == 0)
            chk("unexpected_word", o_instr, 32'hxxxx_xxxx);
         else
            chk("word", o_instr, q.pop_front());
         pops++;
      end
   end

   task automatic drive(input logic [3:0] fmt, input logic [2:0] f3, input logic alt,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm);
      i_fmt = fmt; i_funct3 = f3; i_alt = alt; i_rd = rd; i_rs1 = rs1; i_rs2 = rs2; i_imm = imm;
      i_valid = 1'b1;
   endtask

   // Called at posedge+1; returns at posedge+1 right after the accepting edge.
   task automatic send(input logic [3:0] fmt, input logic [2:0] f3, input logic alt,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm, input logic legal, input logic [31:0] exp);
      int n = 0;
      drive(fmt, f3, alt, rd, rs1, rs2, imm);
      if (legal) q.push_back(exp);
      while (!o_ready && n < 20) begin
         @(posedge clk); #1; n++;
      end
      if (!o_ready) chk("ready_timeout", 32'(o_ready), 32'd1);
      @(posedge clk); #1;
      i_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (q.size() != 0 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      @(posedge clk); #1;
      chk(tag, 32'(q.size()), 32'd0);
   endtask

   initial begin
      int p0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_instr", o_instr, 32'd0);
      chk("rst_err", 32'(o_err), 32'd0);
      chk("rst_err_cnt", 32'(o_err_cnt), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_ready", 32'(o_ready), 32'd1);

      // Encodings
      i_ready = 1'b1;
      send(4'd0, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0,          1'b1, 32'h002081B3);
      send(4'd1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF,  1'b1, 32'hFFF00093);
      send(4'd1, 3'b101, 1'b1, 5'd1, 5'd1, 5'd0, 32'd3,          1'b1, 32'h4030D093);
      send(4'd3, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd4,          1'b1, 32'h0020A223);
      send(4'd4, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'd8,          1'b1, 32'h00000463);
      send(4'd7, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000,   1'b1, 32'h123452B7);
      send(4'd5, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'h800,        1'b1, 32'h001000EF);
      send(4'd6, 3'b111, 1'b0, 5'd1, 5'd2, 5'd0, 32'd4,          1'b1, 32'h004100E7);
      send(4'd8, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'h1000,       1'b1, 32'h00001097);
      send(4'd2, 3'b010, 1'b0, 5'd5, 5'd2, 5'd0, 32'hFFFF_FFFC,  1'b1, 32'hFFC12283);
      drain("drain_encodings");

      // Illegal bundles
      send(4'd4, 3'b010, 1'b0, 5'd0, 5'd0, 5'd0, 32'd8, 1'b0, 32'd0);
      chk("err_pulse", 32'(o_err), 32'd1);
      chk("err_cnt_1", 32'(o_err_cnt), 32'd1);
      @(posedge clk); #1;
      chk("err_pulse_end", 32'(o_err), 32'd0);
      chk("no_word_on_err", 32'(o_valid), 32'd0);
      send(4'd12, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 32'd0);
      chk("err_cnt_2", 32'(o_err_cnt), 32'd2);
      send(4'd0, 3'b001, 1'b1, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0, 32'd0);
      send(4'd2, 3'b011, 1'b0, 5'd1, 5'd1, 5'd0, 32'd0, 1'b0, 32'd0);
      send(4'd3, 3'b011, 1'b0, 5'd0, 5'd1, 5'd1, 32'd0, 1'b0, 32'd0);
      chk("err_cnt_5", 32'(o_err_cnt), 32'd5);

      // Odd branch offset
`ifdef INST_ENCODER_IMM_CHECK_EN
      send(4'd4, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'd7, 1'b0, 32'd0);
      chk("imm_odd_rejected", 32'(o_err_cnt), 32'd6);
`else
      send(4'd4, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'd7, 1'b1, 32'h00000363);
      chk("imm_odd_truncated", 32'(o_err_cnt), 32'd5);
`endif
      drain("drain_illegal");

      // Backpressure: fill, hold a fifth bundle, then release
      i_ready = 1'b0;
      send(4'd0, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0,         1'b1, 32'h002081B3);
      send(4'd1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1, 32'hFFF00093);
      send(4'd3, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd4,         1'b1, 32'h0020A223);
      send(4'd4, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'd8,         1'b1, 32'h00000463);
      chk("full_ready", 32'(o_ready), 32'd0);
      drive(4'd7, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000);
      q.push_back(32'h123452B7);
      repeat (2) begin @(posedge clk); #1; end
      chk("held_ready", 32'(o_ready), 32'd0);
      chk("stall_valid", 32'(o_valid), 32'd1);
      chk("stall_instr", o_instr, 32'h002081B3);
      p0 = pops;
      i_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         if (k == 1) i_valid = 1'b0;
      end
      chk("burst_pops", 32'(pops - p0), 32'd5);
      chk("burst_empty", 32'(q.size()), 32'd0);

      // Simultaneous push and pop at count 2
      i_ready = 1'b0;
      send(4'd8, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'h1000,  1'b1, 32'h00001097);
      send(4'd6, 3'b111, 1'b0, 5'd1, 5'd2, 5'd0, 32'd4,     1'b1, 32'h004100E7);
      drive(4'd5, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'h800);
      q.push_back(32'h001000EF);
      i_ready = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0;
      chk("pushpop_count", 32'(dut.r_count), 32'd2);
      drain("drain_pushpop");

      // Reset mid-stream
      i_ready = 1'b0;
      send(4'd0, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3);
      send(4'd1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h00500093);
      send(4'd4, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'd8, 1'b1, 32'h00000463);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", 32'(o_valid), 32'd0);
      chk("midrst_err_cnt", 32'(o_err_cnt), 32'd0);
      q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("midrst_count", 32'(dut.r_count), 32'd0);
      chk("midrst_ready", 32'(o_ready), 32'd1);
      chk("midrst_instr", o_instr, 32'd0);
      i_ready = 1'b1;
      send(4'd7, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1, 32'h123452B7);
      drain("drain_after_reset");

      // Error counter saturation
      for (int k = 0; k < 256; k++)
         send(4'd15, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 32'd0);
      chk("err_cnt_sat", 32'(o_err_cnt), 32'd255);
      send(4'd9, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 32'd0);
      chk("err_cnt_hold", 32'(o_err_cnt), 32'd255);
      chk("final_empty", 32'(q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
